sprite_motion_ctrl: RTL and testbench
=====================================

Name: sprite_motion_ctrl

Overview:
- Frame-synchronised motion controller that drives the centre position of one sphere sprite. It bounces the sphere inside the visible area and sits directly upstream of the sphere renderers.
- It watches the VGA core's h/v read counters and updates position only once per frame, at the start of vertical blanking, so the image never tears.
- A debounced push-button steps the movement speed.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
RADIUS, 32, sphere radius in pixels; sets the bounce limits
INIT_H, 320, horizontal centre after reset
INIT_V, 240, vertical centre after reset
DEBOUNCE_CYCLES, 250000, number of stable clk cycles required to accept a button level change (~10 ms at 25.175 MHz)
MAX_SPEED, 7, highest speed step in pixels per frame (must be less than RADIUS)

Ports:
clk  input  1  pixel clock (25.175 MHz)
reset  input  1  asynchronous, active-high reset
h_readwire  input  10  horizontal pixel counter from the VGA core
v_readwire  input  10  vertical line counter from the VGA core
enable  input  1  when low, position and direction are frozen
butt_speed  input  1  raw, asynchronous speed button (active-high)
pos_h  output  10  sphere centre x, registered
pos_v  output  10  sphere centre y, registered
dir_h  output  1  1 = moving right, 0 = moving left
dir_v  output  1  1 = moving down, 0 = moving up
speed  output  3  current step in pixels per frame
frame_tick  output  1  one-cycle pulse at each frame update

Behaviour:
- Reset values (applied asynchronously):
  - pos_h=INIT_H, pos_v=INIT_V
  - dir_h=1, dir_v=1
  - speed=1
  - frame_tick=0
  - debounce FSM in IDLE, debounce counter 0, synchroniser flops 0
- Frame tick:
  - Raw match condition: v_readwire==V_ACTIVE and h_readwire==0.
  - frame_tick is high in the cycle after the match, for exactly one cycle.
  - If the counters stall on the match value, only one tick is produced per rising edge of the match condition.
- Position update:
  - Happens on the same clock edge that raises frame_tick, and only if enable=1 and speed!=0.
  - enable=0 or speed==0: pos and dir hold; frame_tick still pulses.
  - Arithmetic uses 11-bit intermediates; there is no wrap-around.
  - Horizontal limits: HMAX = H_ACTIVE-1-RADIUS, HMIN = RADIUS.
  - dir_h=1: nxt = pos_h+speed. If nxt >= HMAX, then pos_h=HMAX and dir_h<=0. Otherwise pos_h=nxt.
  - dir_h=0: if pos_h <= HMIN+speed, then pos_h=HMIN and dir_h<=1. Otherwise pos_h=pos_h-speed.
  - Vertical axis: identical, using VMAX = V_ACTIVE-1-RADIUS and VMIN = RADIUS.
  - Both axes update independently on the same tick, so a corner hit flips both directions.
- Speed button:
  - 2-flop synchroniser, then the debounce FSM, then a single-cycle press pulse.
  - Debounce FSM states:
    - IDLE: sync=1 → PRESS_WAIT, counter cleared.
    - PRESS_WAIT: sync=0 → IDLE. Counter reaches DEBOUNCE_CYCLES-1 → HELD, with a press pulse on that transition.
    - HELD: sync=0 → RELEASE_WAIT, counter cleared.
    - RELEASE_WAIT: sync=1 → HELD. Counter reaches DEBOUNCE_CYCLES-1 → IDLE.
  - Press pulse effect: speed increments. After MAX_SPEED comes 0 (paused), then 1, and so on.
  - A held button produces exactly one press.
- Simultaneous events:
  - If a press pulse and a position update fall on the same edge, the position update uses the old speed.
  - The new speed takes effect at the next tick.
- Reset mid-frame or mid-debounce: everything returns to reset values immediately; nothing partial is retained.
- Outputs are fully registered, with no combinational path from inputs to outputs.

Test Plan:
1. Reset, then run counters to v=480, h=0 → frame_tick high one cycle later for 1 cycle. pos_h=321, pos_v=241 (speed 1). Run 3 more frames → pos_h=324.
2. Force pos_h=605 (HMAX=607), speed=3, dir_h=1, then tick → pos_h=607, dir_h=0. Next tick → pos_h=604.
3. Force pos_h=34 (HMIN=32), speed=3, dir_h=0, then tick → pos_h=32, dir_h=1. Corner case pos_v=34, dir_v=0 on the same tick → both directions flip.
4. Button bounce: toggle butt_speed every 1000 cycles for 10 toggles, then hold high 260000 cycles → speed goes 1→2 exactly once. Release with bounce → no further change.
5. Eight clean presses starting from speed=1 → sequence 2,3,4,5,6,7,0,1. At speed 0, a tick leaves pos/dir unchanged while frame_tick still pulses.
6. enable=0 across 2 frames → pos frozen, 2 ticks seen. Assert reset mid-PRESS_WAIT and mid-frame → all outputs at reset values in the same cycle, and no press is registered after release of reset.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - frame-synchronised bouncing sprite centre with debounced speed button
// Position moves once per frame at the start of vertical blanking.
module sprite_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int RADIUS          = 32,
    parameter int INIT_H          = 320,
    parameter int INIT_V          = 240,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_SPEED       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_readwire,
    input  logic [9:0] v_readwire,
    input  logic       enable,
    input  logic       butt_speed,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v,
    output logic       dir_h,
    output logic       dir_v,
    output logic [2:0] speed,
    output logic       frame_tick
);

    localparam int          CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0] HMAX      = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] HMIN      = 11'(RADIUS);
    localparam logic [10:0] VMAX      = 11'(V_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] VMIN      = 11'(RADIUS);
    localparam logic [9:0]  V_MATCH   = 10'(V_ACTIVE);
    localparam logic [9:0]  INIT_H_L  = 10'(INIT_H);
    localparam logic [9:0]  INIT_V_L  = 10'(INIT_V);
    localparam logic [2:0]  SPEED_MAX = 3'(MAX_SPEED);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } db_state_t;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             match_q, match_d;
    logic             tick_q, tick_d;
    logic [9:0]       pos_h_q, pos_h_d;
    logic [9:0]       pos_v_q, pos_v_d;
    logic             dir_h_q, dir_h_d;
    logic             dir_v_q, dir_v_d;
    logic [2:0]       speed_q, speed_d;
    logic             press;

    // Returns {new_dir, new_pos}; 11-bit math so the upper limit compare cannot wrap.
    function automatic logic [10:0] axis_next(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [2:0]  spd,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] cur;
        logic [10:0] stp;
        logic [10:0] inc;
        logic [9:0]  dec;
        cur = {1'b0, pos};
        stp = {8'b0, spd};
        inc = cur + stp;
        dec = pos - {7'b0, spd};
        if (dir) begin
            if (inc >= hi) begin
                axis_next = {1'b0, hi[9:0]};
            end else begin
                axis_next = {1'b1, inc[9:0]};
            end
        end else begin
            if (cur <= lo + stp) begin
                axis_next = {1'b1, lo[9:0]};
            end else begin
                axis_next = {1'b0, dec};
            end
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            match_q <= 1'b0;
            tick_q  <= 1'b0;
            pos_h_q <= INIT_H_L;
            pos_v_q <= INIT_V_L;
            dir_h_q <= 1'b1;
            dir_v_q <= 1'b1;
            speed_q <= 3'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            match_q <= match_d;
            tick_q  <= tick_d;
            pos_h_q <= pos_h_d;
            pos_v_q <= pos_v_d;
            dir_h_q <= dir_h_d;
            dir_v_q <= dir_v_d;
            speed_q <= speed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        sync1_d = butt_speed;
        sync2_d = sync1_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Position always steps with the speed held before this edge's press, if any.
    always_comb begin
        match_d = (v_readwire == V_MATCH) && (h_readwire == 10'd0);
        tick_d  = match_d && !match_q;
        pos_h_d = pos_h_q;
        pos_v_d = pos_v_q;
        dir_h_d = dir_h_q;
        dir_v_d = dir_v_q;
        speed_d = speed_q;
        if (tick_d && enable && (speed_q != 3'd0)) begin
            {dir_h_d, pos_h_d} = axis_next(pos_h_q, dir_h_q, speed_q, HMIN, HMAX);
            {dir_v_d, pos_v_d} = axis_next(pos_v_q, dir_v_q, speed_q, VMIN, VMAX);
        end
        if (press) begin
            speed_d = (speed_q == SPEED_MAX) ? 3'd0 : speed_q + 3'd1;
        end
    end

    assign pos_h      = pos_h_q;
    assign pos_v      = pos_v_q;
    assign dir_h      = dir_h_q;
    assign dir_v      = dir_v_q;
    assign speed      = speed_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed table-driven bench for sprite_motion_ctrl
module tb_sprite_motion_ctrl;

    localparam int DB = 16;

    typedef struct {
        int ticks;
        bit en;
        int exp_h;
        int exp_v;
        bit exp_dh;
        bit exp_dv;
    } fvec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h_rd, v_rd;
    logic       en_a, en_b, butt_a, butt_b;
    logic [9:0] pos_h_a, pos_v_a, pos_h_b, pos_v_b;
    logic       dir_h_a, dir_v_a, dir_h_b, dir_v_b;
    logic [2:0] speed_a, speed_b;
    logic       ft_a, ft_b;

    int checks = 0;
    int errors = 0;

    fvec_t main_tbl[6];
    fvec_t edge_tbl[8];
    int    speed_seq[6];

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.DEBOUNCE_CYCLES(DB)) u_a (
        .clk(clk), .reset(reset), .h_readwire(h_rd), .v_readwire(v_rd),
        .enable(en_a), .butt_speed(butt_a),
        .pos_h(pos_h_a), .pos_v(pos_v_a), .dir_h(dir_h_a), .dir_v(dir_v_a),
        .speed(speed_a), .frame_tick(ft_a)
    );

    sprite_motion_ctrl #(.DEBOUNCE_CYCLES(DB), .INIT_H(601), .INIT_V(441)) u_b (
        .clk(clk), .reset(reset), .h_readwire(h_rd), .v_readwire(v_rd),
        .enable(en_b), .butt_speed(butt_b),
        .pos_h(pos_h_b), .pos_v(pos_v_b), .dir_h(dir_h_b), .dir_v(dir_v_b),
        .speed(speed_b), .frame_tick(ft_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input string name);
        @(negedge clk);
        v_rd = 10'd480; h_rd = 10'd0;
        @(negedge clk);
        check({name, " tick high"}, 32'(ft_a), 1);
        v_rd = 10'd0; h_rd = 10'd1;
        @(negedge clk);
        check({name, " tick low"}, 32'(ft_a), 0);
    endtask

    task automatic frame_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v_rd = 10'd480; h_rd = 10'd0;
            @(negedge clk);
            v_rd = 10'd0; h_rd = 10'd1;
        end
    endtask

    task automatic press_a();
        butt_a = 1'b1; idle(DB + 8);
        butt_a = 1'b0; idle(DB + 8);
    endtask

    task automatic press_b();
        butt_b = 1'b1; idle(DB + 8);
        butt_b = 1'b0; idle(DB + 8);
    endtask

    task automatic check_a(input string name, input int h, input int v, input int dh, input int dv);
        check({name, " pos_h"}, 32'(pos_h_a), h);
        check({name, " pos_v"}, 32'(pos_v_a), v);
        check({name, " dir_h"}, 32'(dir_h_a), dh);
        check({name, " dir_v"}, 32'(dir_v_a), dv);
    endtask

    initial begin
        int ticks_seen;

        main_tbl[0] = '{1, 1'b1, 321, 241, 1'b1, 1'b1};
        main_tbl[1] = '{1, 1'b1, 322, 242, 1'b1, 1'b1};
        main_tbl[2] = '{1, 1'b0, 322, 242, 1'b1, 1'b1};
        main_tbl[3] = '{1, 1'b1, 323, 243, 1'b1, 1'b1};
        main_tbl[4] = '{1, 1'b0, 323, 243, 1'b1, 1'b1};
        main_tbl[5] = '{1, 1'b1, 324, 244, 1'b1, 1'b1};

        edge_tbl[0] = '{1,   1'b1, 604, 444, 1'b1, 1'b1};
        edge_tbl[1] = '{1,   1'b1, 607, 447, 1'b0, 1'b0};
        edge_tbl[2] = '{1,   1'b1, 604, 444, 1'b0, 1'b0};
        edge_tbl[3] = '{137, 1'b1, 193, 33,  1'b0, 1'b0};
        edge_tbl[4] = '{1,   1'b1, 190, 32,  1'b0, 1'b1};
        edge_tbl[5] = '{52,  1'b1, 34,  188, 1'b0, 1'b1};
        edge_tbl[6] = '{1,   1'b1, 32,  191, 1'b1, 1'b1};
        edge_tbl[7] = '{1,   1'b1, 35,  194, 1'b1, 1'b1};

        speed_seq = '{3, 4, 5, 6, 7, 0};

        reset = 1'b1; butt_a = 1'b0; butt_b = 1'b0;
        en_a = 1'b1; en_b = 1'b0;
        v_rd = 10'd0; h_rd = 10'd1;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check_a("reset", 320, 240, 1, 1);
        check("reset speed", 32'(speed_a), 1);
        check("reset tick", 32'(ft_a), 0);
        check("reset b pos_h", 32'(pos_h_b), 601);
        check("reset b pos_v", 32'(pos_v_b), 441);

        for (int i = 0; i < 6; i++) begin
            en_a = main_tbl[i].en;
            for (int t = 0; t < main_tbl[i].ticks; t++) frame($sformatf("tbl%0d", i));
            check_a($sformatf("tbl%0d", i), main_tbl[i].exp_h, main_tbl[i].exp_v,
                    main_tbl[i].exp_dh, main_tbl[i].exp_dv);
        end

        // counters stalled on the match value
        ticks_seen = 0;
        @(negedge clk); v_rd = 10'd480; h_rd = 10'd0;
        repeat (5) begin @(negedge clk); ticks_seen += int'(ft_a); end
        v_rd = 10'd0; h_rd = 10'd1;
        @(negedge clk); ticks_seen += int'(ft_a);
        check("stall tick count", ticks_seen, 1);
        check_a("stall", 325, 245, 1, 1);

        // h mismatch on the blanking line must not tick
        @(negedge clk); v_rd = 10'd480; h_rd = 10'd1;
        @(negedge clk); check("no tick h!=0", 32'(ft_a), 0);
        v_rd = 10'd0;
        @(negedge clk);
        check("no tick pos_h", 32'(pos_h_a), 325);

        // bouncy press, then long hold, then bouncy release
        for (int k = 0; k < 10; k++) begin butt_a = ~butt_a; idle(5); end
        check("bounce no press", 32'(speed_a), 1);
        butt_a = 1'b1; idle(DB + 8);
        check("bounce press", 32'(speed_a), 2);
        idle(60);
        check("held single press", 32'(speed_a), 2);
        for (int k = 0; k < 10; k++) begin butt_a = ~butt_a; idle(5); end
        butt_a = 1'b0; idle(DB + 8);
        check("bounce release", 32'(speed_a), 2);

        for (int i = 0; i < 6; i++) begin
            press_a();
            check($sformatf("press seq%0d", i), 32'(speed_a), speed_seq[i]);
        end
        frame("pause");
        check_a("pause", 325, 245, 1, 1);
        press_a();
        check("press wrap to 1", 32'(speed_a), 1);
        frame("resume");
        check_a("resume", 326, 246, 1, 1);

        // press pulse lands on the same edge as the tick
        @(negedge clk); butt_a = 1'b1;
        repeat (18) @(negedge clk);
        v_rd = 10'd480; h_rd = 10'd0;
        @(negedge clk);
        check("simul tick", 32'(ft_a), 1);
        check("simul old speed pos_h", 32'(pos_h_a), 327);
        check("simul old speed pos_v", 32'(pos_v_a), 247);
        check("simul new speed", 32'(speed_a), 2);
        v_rd = 10'd0; h_rd = 10'd1;
        butt_a = 1'b0; idle(DB + 8);
        frame("after simul");
        check_a("after simul", 329, 249, 1, 1);

        en_a = 1'b0;
        frame("frozen0");
        frame("frozen1");
        check_a("frozen", 329, 249, 1, 1);
        en_a = 1'b1;

        // reset in the middle of PRESS_WAIT and while frame_tick is high
        butt_a = 1'b1; idle(8);
        v_rd = 10'd480; h_rd = 10'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_a("async reset", 320, 240, 1, 1);
        check("async reset speed", 32'(speed_a), 1);
        check("async reset tick", 32'(ft_a), 0);
        v_rd = 10'd0; h_rd = 10'd1;
        @(negedge clk); reset = 1'b0;
        idle(10);
        butt_a = 1'b0; idle(DB + 8);
        check("no press after reset", 32'(speed_a), 1);

        // second instance: bounce limits and a corner hit
        en_a = 1'b0;
        press_b(); press_b();
        check("b speed 3", 32'(speed_b), 3);
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame_quiet(edge_tbl[i].ticks);
            @(negedge clk);
            check($sformatf("edge%0d pos_h", i), 32'(pos_h_b), edge_tbl[i].exp_h);
            check($sformatf("edge%0d pos_v", i), 32'(pos_v_b), edge_tbl[i].exp_v);
            check($sformatf("edge%0d dir_h", i), 32'(dir_h_b), 32'(edge_tbl[i].exp_dh));
            check($sformatf("edge%0d dir_v", i), 32'(dir_v_b), 32'(edge_tbl[i].exp_dv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
